// File: rtl/mem_stage_sram_if.sv
// SRAM port bundle between the memory stage (master) and a 16-bit
// asynchronous SRAM (slave).
interface mem_stage_sram_if #(
    parameter int AW = 18
);
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_wdata;
    logic [15:0]   sram_rdata;
    logic          sram_we_n;
    logic          sram_oe_n;

    modport master (
        output sram_addr,
        output sram_wdata,
        output sram_we_n,
        output sram_oe_n,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr,
        input  sram_wdata,
        input  sram_we_n,
        input  sram_oe_n,
        output sram_rdata
    );
endinterface

// File: rtl/mem_stage_sram.sv
// Memory stage of the 32-bit pipeline. Word loads/stores are split into two
// half-word SRAM accesses (LO then HI); the pipeline is held with freeze
// until the access completes, then the MEM/WB register captures the result.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no access in flight; a request starts the LO half
// LO    | SRAM driven with the low half-word address/data
// HI    | SRAM driven with the high half-word address/data
// DONE  | access complete, freeze dropped so MEM/WB can load
module mem_stage_sram #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          AW          = 18,
    parameter int          WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        WB_EN,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_rm,
    input  logic [3:0]  dest,

    output logic        freeze,

    output logic        WB_EN_OUT,
    output logic        MEM_R_EN_OUT,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data_out,
    output logic [3:0]  dest_out,

    output logic [3:0]  MEM_dst,
    output logic        MEM_WB_EN,

    mem_stage_sram_if.master sram
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   wdata;
        logic          we_n;
        logic          oe_n;
    } drive_t;

    localparam logic [2:0] WAIT_C = 3'(WAIT_CYCLES);

    state_t        state;
    logic [2:0]    cnt;
    logic [31:0]   rd_buf;
    drive_t        drv;

    logic          req;
    logic          is_read;
    logic [AW-1:0] addr_lo;
    logic [AW-1:0] addr_hi;

    function automatic drive_t drv_idle();
        drive_t d;
        d.addr  = '0;
        d.wdata = '0;
        d.we_n  = 1'b1;
        d.oe_n  = 1'b1;
        return d;
    endfunction

    // Reads enable the output driver only; writes drive data and strobe WE.
    function automatic drive_t drv_half(input logic [AW-1:0] a,
                                        input logic [15:0]   d_in,
                                        input logic          rd);
        drive_t d;
        d.addr  = a;
        d.wdata = rd ? 16'h0000 : d_in;
        d.we_n  = rd;
        d.oe_n  = ~rd;
        return d;
    endfunction

    // Request decode and half-word address generation. The word offset is
    // (alu_res - BASE_ADDR) >> 2; shifting by one and clearing bit 0 yields
    // the LO half-word address directly, wrapping modulo 2^AW.
    always_comb begin
        req     = MEM_R_EN | MEM_W_EN;
        is_read = MEM_R_EN;
        addr_lo = AW'((alu_res - BASE_ADDR) >> 1) & ~AW'(1);
        addr_hi = addr_lo | AW'(1);
        freeze  = req & (state != S_DONE) & ~rst;
    end

    assign MEM_dst   = dest;
    assign MEM_WB_EN = WB_EN;

    assign sram.sram_addr  = drv.addr;
    assign sram.sram_wdata = drv.wdata;
    assign sram.sram_we_n  = drv.we_n;
    assign sram.sram_oe_n  = drv.oe_n;

    // Access sequencer; SRAM drive is registered and set up on the edge that
    // enters each half, so it is valid for the whole LO/HI window.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= 3'd0;
            rd_buf <= 32'h0;
            drv    <= drv_idle();
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        state <= S_LO;
                        cnt   <= 3'd0;
                        drv   <= drv_half(addr_lo, val_rm[15:0], is_read);
                    end
                end
                S_LO: begin
                    if (cnt == WAIT_C) begin
                        if (is_read) begin
                            rd_buf[15:0] <= sram.sram_rdata;
                        end
                        state <= S_HI;
                        cnt   <= 3'd0;
                        drv   <= drv_half(addr_hi, val_rm[31:16], is_read);
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_HI: begin
                    if (cnt == WAIT_C) begin
                        if (is_read) begin
                            rd_buf[31:16] <= sram.sram_rdata;
                        end
                        state <= S_DONE;
                        cnt   <= 3'd0;
                        drv   <= drv_idle();
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= 3'd0;
                    drv   <= drv_idle();
                end
            endcase
        end
    end

    // MEM/WB pipeline register; a bubble is inserted while the stage is frozen.
    always_ff @(posedge clk) begin
        if (rst || freeze) begin
            WB_EN_OUT    <= 1'b0;
            MEM_R_EN_OUT <= 1'b0;
            alu_res_out  <= 32'h0;
            mem_data_out <= 32'h0;
            dest_out     <= 4'h0;
        end else begin
            WB_EN_OUT    <= WB_EN;
            MEM_R_EN_OUT <= MEM_R_EN;
            alu_res_out  <= alu_res;
            mem_data_out <= MEM_R_EN ? rd_buf : 32'h0;
            dest_out     <= dest;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Directed bench for mem_stage_sram: one instance with WAIT_CYCLES=1 and one
// with WAIT_CYCLES=0, each attached to its own behavioural 16-bit SRAM.
module tb_mem_stage_sram;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN, MEM_R_EN, MEM_W_EN;
    logic [31:0] alu_res, val_rm;
    logic [3:0]  dest;

    logic        freeze1, wb1, mr1, memwb1;
    logic [31:0] alu1, md1;
    logic [3:0]  dst1, memdst1;

    logic        freeze0, wb0, mr0, memwb0;
    logic [31:0] alu0, md0;
    logic [3:0]  dst0, memdst0;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_sram_if #(.AW(18)) sif1 ();
    mem_stage_sram_if #(.AW(18)) sif0 ();

    logic [15:0] mem1 [0:262143];
    logic [15:0] mem0 [0:262143];

    always #5 clk = ~clk;

    mem_stage_sram #(.BASE_ADDR(32'd1024), .AW(18), .WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
        .freeze(freeze1),
        .WB_EN_OUT(wb1), .MEM_R_EN_OUT(mr1), .alu_res_out(alu1),
        .mem_data_out(md1), .dest_out(dst1),
        .MEM_dst(memdst1), .MEM_WB_EN(memwb1),
        .sram(sif1.master)
    );

    mem_stage_sram #(.BASE_ADDR(32'd1024), .AW(18), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .alu_res(alu_res), .val_rm(val_rm), .dest(dest),
        .freeze(freeze0),
        .WB_EN_OUT(wb0), .MEM_R_EN_OUT(mr0), .alu_res_out(alu0),
        .mem_data_out(md0), .dest_out(dst0),
        .MEM_dst(memdst0), .MEM_WB_EN(memwb0),
        .sram(sif0.master)
    );

    // SRAM models: synchronous write strobe, combinational read when OE is low.
    always @(posedge clk) begin
        if (!sif1.sram_we_n) mem1[sif1.sram_addr] <= sif1.sram_wdata;
        if (!sif0.sram_we_n) mem0[sif0.sram_addr] <= sif0.sram_wdata;
    end
    assign sif1.sram_rdata = sif1.sram_oe_n ? 16'h0000 : mem1[sif1.sram_addr];
    assign sif0.sram_rdata = sif0.sram_oe_n ? 16'h0000 : mem0[sif0.sram_addr];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Called with an op already applied in its cycle 0. Counts freeze cycles,
    // then steps past the DONE/issue cycle so MEM/WB shows the result.
    task automatic run_op(input bit use_w0, output int nfz);
        logic fz;
        nfz = 0;
        #1;
        fz = use_w0 ? freeze0 : freeze1;
        while (fz && nfz < 50) begin
            nfz++;
            tick();
            #1;
            fz = use_w0 ? freeze0 : freeze1;
        end
        check("freeze_bound", {31'd0, fz}, 32'd0);
        tick();
        #1;
    endtask

    task automatic set_op(input logic wb, input logic mr, input logic mw,
                          input logic [31:0] a, input logic [31:0] v, input logic [3:0] d);
        WB_EN = wb; MEM_R_EN = mr; MEM_W_EN = mw;
        alu_res = a; val_rm = v; dest = d;
    endtask

    logic [17:0] st_addr [0:3];
    logic [15:0] st_data [0:3];
    int nfz;

    initial begin
        st_addr[0] = 18'd4;     st_addr[1] = 18'd4;
        st_addr[2] = 18'd5;     st_addr[3] = 18'd5;
        st_data[0] = 16'hBEEF;  st_data[1] = 16'hBEEF;
        st_data[2] = 16'hDEAD;  st_data[3] = 16'hDEAD;
        mem1[4] = 16'h1111;
        mem1[5] = 16'h2222;

        // Reset with a read request held.
        rst = 1'b1;
        set_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd2);
        tick(); tick(); #1;
        check("rst_freeze", {31'd0, freeze1}, 32'd0);
        check("rst_wb",     {31'd0, wb1}, 32'd0);
        check("rst_mr",     {31'd0, mr1}, 32'd0);
        check("rst_alu",    alu1, 32'd0);
        check("rst_md",     md1, 32'd0);
        check("rst_dest",   {28'd0, dst1}, 32'd0);
        check("rst_we_n",   {31'd0, sif1.sram_we_n}, 32'd1);
        check("rst_oe_n",   {31'd0, sif1.sram_oe_n}, 32'd1);
        check("rst_addr",   {14'd0, sif1.sram_addr}, 32'd0);
        check("rst_wdata",  {16'd0, sif1.sram_wdata}, 32'd0);

        // Release: held read starts immediately.
        tick();
        rst = 1'b0;
        run_op(1'b0 == 1'b1, nfz);
        check("rel_fz_cycles", nfz, 32'd5);
        check("rel_md",   md1, 32'h22221111);
        check("rel_mr",   {31'd0, mr1}, 32'd1);
        check("rel_dest", {28'd0, dst1}, 32'd2);

        // ALU op passes through with one cycle of latency.
        set_op(1'b1, 1'b0, 1'b0, 32'h0000_0123, 32'h0, 4'd5);
        #1;
        check("alu_freeze", {31'd0, freeze1}, 32'd0);
        check("alu_memdst", {28'd0, memdst1}, 32'd5);
        check("alu_memwb",  {31'd0, memwb1}, 32'd1);
        tick(); #1;
        check("alu_wb",   {31'd0, wb1}, 32'd1);
        check("alu_res",  alu1, 32'h123);
        check("alu_dest", {28'd0, dst1}, 32'd5);
        check("alu_mr",   {31'd0, mr1}, 32'd0);

        // Store 0xDEADBEEF to 1032, cycle by cycle.
        set_op(1'b0, 1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF, 4'd0);
        #1;
        check("st_c0_freeze", {31'd0, freeze1}, 32'd1);
        check("st_c0_we_n",   {31'd0, sif1.sram_we_n}, 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick(); #1;
            check("st_freeze", {31'd0, freeze1}, 32'd1);
            check("st_addr",   {14'd0, sif1.sram_addr}, {14'd0, st_addr[c]});
            check("st_wdata",  {16'd0, sif1.sram_wdata}, {16'd0, st_data[c]});
            check("st_we_n",   {31'd0, sif1.sram_we_n}, 32'd0);
            check("st_oe_n",   {31'd0, sif1.sram_oe_n}, 32'd1);
        end
        tick(); #1;
        check("st_done_freeze", {31'd0, freeze1}, 32'd0);
        check("st_done_we_n",   {31'd0, sif1.sram_we_n}, 32'd1);
        check("st_done_addr",   {14'd0, sif1.sram_addr}, 32'd0);
        tick(); #1;
        check("st_wb",  {31'd0, wb1}, 32'd0);
        check("st_alu", alu1, 32'd1032);
        check("st_md",  md1, 32'd0);

        // Back-to-back load from the same address.
        set_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd7);
        run_op(1'b0, nfz);
        check("ld_fz_cycles", nfz, 32'd5);
        check("ld_md",   md1, 32'hDEAD_BEEF);
        check("ld_mr",   {31'd0, mr1}, 32'd1);
        check("ld_wb",   {31'd0, wb1}, 32'd1);
        check("ld_dest", {28'd0, dst1}, 32'd7);

        // Zero-wait instance: store then load 1040.
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(1'b0, 1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D, 4'd0);
        run_op(1'b1, nfz);
        check("w0_st_fz_cycles", nfz, 32'd3);
        check("w0_mem_lo", {16'd0, mem0[8]}, 32'h0000F00D);
        check("w0_mem_hi", {16'd0, mem0[9]}, 32'h0000CAFE);
        set_op(1'b1, 1'b1, 1'b0, 32'd1040, 32'h0, 4'd9);
        run_op(1'b1, nfz);
        check("w0_ld_fz_cycles", nfz, 32'd3);
        check("w0_ld_md",   md0, 32'hCAFE_F00D);
        check("w0_ld_dest", {28'd0, dst0}, 32'd9);

        // Address below BASE_ADDR wraps to the top of SRAM.
        set_op(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_op(1'b0, 1'b0, 1'b1, 32'd1020, 32'h1234_5678, 4'd0);
        tick(); #1;
        check("wrap_lo_addr", {14'd0, sif1.sram_addr}, 32'h3FFFE);
        tick(); tick(); #1;
        check("wrap_hi_addr", {14'd0, sif1.sram_addr}, 32'h3FFFF);
        run_op(1'b0, nfz);

        // Reset asserted in cycle 3 of a load aborts it.
        set_op(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd3);
        tick(); tick(); tick();
        rst = 1'b1;
        #1;
        check("mid_rst_freeze", {31'd0, freeze1}, 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check("mid_oe_n", {31'd0, sif1.sram_oe_n}, 32'd1);
        check("mid_addr", {14'd0, sif1.sram_addr}, 32'd0);
        check("mid_wb",   {31'd0, wb1}, 32'd0);
        check("mid_md",   md1, 32'd0);
        check("mid_dest", {28'd0, dst1}, 32'd0);
        run_op(1'b0, nfz);
        check("mid_restart_fz", nfz, 32'd5);
        check("mid_restart_md", md1, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
